// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_pkg
//  Description : Shared types and constants for the bit-serial magnitude
//                comparator (FSM state encoding, result-vector bit order).
//  Revision    : 1.0 - initial release
// ============================================================================
package cmp_pkg;

    // Controller states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Result vector layout, kept in the legacy {S, I, E} order
    localparam int RES_W  = 3;
    localparam int RES_GT = 2;
    localparam int RES_LT = 1;
    localparam int RES_EQ = 0;

endpackage
`default_nettype wire

// File: rtl/cmp_bit_cell.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_bit_cell
//  Description : One-bit magnitude decision cell. All outputs are gated by g,
//                so a disabled cell reports no relation at all.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_bit_cell (
    input  logic g,
    input  logic a,
    input  logic b,
    output logic gt,
    output logic lt,
    output logic eq
);

    assign gt = g &  a & ~b;
    assign lt = g & ~a &  b;
    assign eq = g & ~(a ^ b);

endmodule
`default_nettype wire

// File: rtl/seq_mag_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mag_cmp
//  Description : Bit-serial MSB-first magnitude comparator behind a
//                start/done handshake. Stops at the first differing bit and
//                holds gt/lt/eq until the next accepted start.
//  Options     : SIGNED_CMP_EN - adds the sgn port; with sgn=1 the MSB
//                decision is inverted for two's-complement operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mag_cmp
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SIGNED_CMP_EN
    input  logic             sgn,
`endif
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int             IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t             state, state_next;
    logic [IDX_W-1:0]   idx, idx_next;
    logic [RES_W-1:0]   res, res_next;
    logic               done_next;
    logic               load;
    logic [WIDTH-1:0]   a_reg, b_reg;

    logic               cell_gt, cell_lt, cell_eq;
    logic               dec_gt, dec_lt;

    // Per-bit decision on the currently indexed operand bits
    cmp_bit_cell u_cell (
        .g  (state == RUN),
        .a  (a_reg[idx]),
        .b  (b_reg[idx]),
        .gt (cell_gt),
        .lt (cell_lt),
        .eq (cell_eq)
    );

`ifdef SIGNED_CMP_EN
    logic sgn_reg;
    logic msb_inv;

    // A set sign bit marks the smaller value, so the MSB verdict flips
    assign msb_inv = sgn_reg && (idx == LAST_IDX);
    assign dec_gt  = msb_inv ? cell_lt : cell_gt;
    assign dec_lt  = msb_inv ? cell_gt : cell_lt;

    // Sign mode is captured together with the operands
    always_ff @(posedge clk) begin
        if (rst) begin
            sgn_reg <= 1'b0;
        end else if (load) begin
            sgn_reg <= sgn;
        end
    end
`else
    assign dec_gt = cell_gt;
    assign dec_lt = cell_lt;
`endif

    // Next-state, index and result decisions
    always_comb begin
        state_next = state;
        idx_next   = idx;
        res_next   = res;
        done_next  = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    res_next = '0;
                    if (en) begin
                        load       = 1'b1;
                        idx_next   = LAST_IDX;
                        state_next = RUN;
                    end else begin
                        // Disabled compare finishes at once with no relation
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (dec_gt || dec_lt || (cell_eq && (idx == '0))) begin
                    res_next         = '0;
                    res_next[RES_GT] = dec_gt;
                    res_next[RES_LT] = dec_lt;
                    res_next[RES_EQ] = ~(dec_gt | dec_lt);
                    done_next        = 1'b1;
                    state_next       = IDLE;
                end else begin
                    // idx==0 always resolves above, so this never wraps
                    idx_next = idx - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Controller and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            res   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            res   <= res_next;
            done  <= done_next;
        end
    end

    // Operand capture on the accepting edge only
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (load) begin
            a_reg <= a;
            b_reg <= b;
        end
    end

    assign busy = (state == RUN);
    assign gt   = res[RES_GT];
    assign lt   = res[RES_LT];
    assign eq   = res[RES_EQ];

endmodule
`default_nettype wire

// File: tb/tb_seq_mag_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_mag_cmp
//  Description : Directed self-checking bench for seq_mag_cmp (WIDTH=8),
//                plus a back-to-back random run against a golden compare.
//  Options     : SIGNED_CMP_EN - also exercises the signed MSB rule.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mag_cmp;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SIGNED_CMP_EN
    logic             sgn;
`endif
    logic             busy;
    logic             done;
    logic             gt;
    logic             lt;
    logic             eq;

    int n_checks;
    int n_fails;

    seq_mag_cmp #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .en    (en),
        .a     (a),
        .b     (b),
`ifdef SIGNED_CMP_EN
        .sgn   (sgn),
`endif
        .busy  (busy),
        .done  (done),
        .gt    (gt),
        .lt    (lt),
        .eq    (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one comparison; returns edges from accept to done and busy cycles
    task automatic run_cmp(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                           input logic ve, output int lat, output int bcnt);
        a     = va;
        b     = vb;
        en    = ve;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        while (!done && lat < WIDTH + 4) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    // Golden unsigned compare: edges to resolve and {gt,lt,eq}
    function automatic int exp_lat(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (va[i] != vb[i]) return WIDTH - i;
        end
        return WIDTH;
    endfunction

    function automatic logic [2:0] exp_res(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
        if (va > vb) return 3'b100;
        if (va < vb) return 3'b010;
        return 3'b001;
    endfunction

    initial begin
        int lat;
        int bcnt;
        int done_seen;
        logic [WIDTH-1:0] ra, rb;

        n_checks = 0;
        n_fails  = 0;
        rst   = 1'b1;
        start = 1'b0;
        en    = 1'b0;
        a     = '0;
        b     = '0;
`ifdef SIGNED_CMP_EN
        sgn   = 1'b0;
`endif
        tick();
        tick();
        check("reset_outputs", {busy, done, gt, lt, eq}, 5'b00000);
        rst = 1'b0;
        tick();
        check("idle_outputs", {busy, done, gt, lt, eq}, 5'b00000);

        // Equal operands walk every bit
        run_cmp(8'hA5, 8'hA5, 1'b1, lat, bcnt);
        check("eq_lat", lat, 8);
        check("eq_busy", bcnt, 8);
        check("eq_res", {gt, lt, eq}, 3'b001);
        check("eq_busy_at_done", busy, 0);
        tick();
        check("eq_done_pulse", done, 0);
        check("eq_res_held", {gt, lt, eq}, 3'b001);

        // MSB decides at once
        run_cmp(8'h80, 8'h7F, 1'b1, lat, bcnt);
        check("msb_lat", lat, 1);
        check("msb_res", {gt, lt, eq}, 3'b100);
        tick();

        // Difference only in the LSB
        run_cmp(8'h12, 8'h13, 1'b1, lat, bcnt);
        check("lsb_lat", lat, 8);
        check("lsb_res", {gt, lt, eq}, 3'b010);
        tick();

        // Difference in bit 6
        run_cmp(8'h40, 8'h10, 1'b1, lat, bcnt);
        check("b6_lat", lat, 2);
        check("b6_res", {gt, lt, eq}, 3'b100);
        tick();

        // Disabled compare: immediate all-zero result, busy never rises
        run_cmp(8'hFF, 8'h00, 1'b0, lat, bcnt);
        check("en0_lat", lat, 0);
        check("en0_busy", {bcnt[3:0], busy}, 5'b00000);
        check("en0_res", {gt, lt, eq}, 3'b000);
        tick();
        check("en0_done_pulse", done, 0);

`ifdef SIGNED_CMP_EN
        sgn = 1'b1;
        run_cmp(8'h80, 8'h7F, 1'b1, lat, bcnt);
        check("sgn_msb_lat", lat, 1);
        check("sgn_msb_res", {gt, lt, eq}, 3'b010);
        tick();
        run_cmp(8'hFE, 8'hFF, 1'b1, lat, bcnt);
        check("sgn_lsb_lat", lat, 8);
        check("sgn_lsb_res", {gt, lt, eq}, 3'b010);
        tick();
        run_cmp(8'h05, 8'hF0, 1'b1, lat, bcnt);
        check("sgn_pos_neg_res", {gt, lt, eq}, 3'b100);
        tick();
        sgn = 1'b0;
`endif

        // Start mid-run is ignored and operands are not re-sampled
        a = 8'h01; b = 8'h00; en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < WIDTH + 4) begin
            if (lat == 2) begin
                a = 8'h00; b = 8'hFF; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        check("ignore_lat", lat, 8);
        check("ignore_res", {gt, lt, eq}, 3'b100);
        tick();
        check("ignore_no_restart", busy, 0);

        // Reset mid-run aborts without a done pulse
        a = 8'h01; b = 8'h00; en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_outputs", {busy, done, gt, lt, eq}, 5'b00000);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) done_seen++;
            tick();
        end
        check("abort_no_done", done_seen, 0);

        // Back-to-back compares with start held high
        en    = 1'b1;
        start = 1'b1;
        ra    = WIDTH'($urandom);
        rb    = ra;
        a = ra; b = rb;
        tick();
        for (int n = 0; n < 1000; n++) begin
            lat = 0;
            while (!done && lat < WIDTH + 4) begin
                tick();
                lat++;
            end
            check("b2b_lat", lat, exp_lat(ra, rb));
            check("b2b_res", {gt, lt, eq}, exp_res(ra, rb));
            ra = WIDTH'($urandom);
            rb = (n % 8 == 3) ? ra : WIDTH'($urandom);
            a = ra; b = rb;
            tick();
        end
        start = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_mag_cmp.md
# seq_mag_cmp

Parametrised, bit-serial magnitude comparator, the successor to the team's 4-bit combinational enable-chained comparator. It compares two WIDTH-bit operands MSB-first, one bit per clock, and terminates early at the first differing bit. Results are held in registers until the next accepted start. It sits behind a start/done handshake so board-level or control logic can issue comparisons without tying up combinational depth at large widths.

## Interface
- WIDTH, 8: operand width in bits, at least 2.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a comparison; accepted only when busy=0.
- en  in  1  compare enable, sampled with start. When 0, the result is all-zero, as in the chained G enable.
- a  in  WIDTH  operand A, sampled on the accepting edge.
- b  in  WIDTH  operand B, sampled on the accepting edge.
- sgn  in  1  two's-complement mode, sampled with start. Present only with SIGNED_CMP_EN.
- busy  out  1  high while a comparison is running.
- done  out  1  one-cycle pulse when the result registers update.
- gt  out  1  a > b, held.
- lt  out  1  a < b, held.
- eq  out  1  a == b, held.

## Operation
- States:
  - IDLE: default state.
  - RUN: active comparison.
- IDLE:
  - With start=1 and en=1: latch a, b and sgn; set bit index idx=WIDTH-1; go to RUN; clear gt, lt and eq.
  - With start=1 and en=0: stay in IDLE; next cycle done=1 and gt=lt=eq=0.
- RUN: each cycle evaluates bit idx through the bit cell.
  - a[idx]=1, b[idx]=0: set gt=1 (lt=1 if signed mode and idx=WIDTH-1); go to IDLE.
  - a[idx]=0, b[idx]=1: set lt=1 (gt=1 if signed mode and idx=WIDTH-1); go to IDLE.
  - Equal bits, idx=0: set eq=1; go to IDLE.
  - Equal bits, idx>0: decrement idx; stay in RUN.
- Exactly one of gt, lt and eq is 1 after any en=1 comparison. All three are 0 after an en=0 comparison.
- start while busy=1 is ignored, with no queuing. Operands are not re-sampled mid-run.
- start high on the done cycle is accepted: state is IDLE by then.
- idx is $clog2(WIDTH) bits wide and never wraps below 0.

## Timing
- Reset values: busy=0, done=0, gt=0, lt=0, eq=0, state=IDLE, idx=0.
- Latency for en=1: start is accepted on edge E0. Bit WIDTH-1 is evaluated in the cycle after E0. If the k-th examined bit resolves the compare (1 ≤ k ≤ WIDTH), the result and done are registered on edge Ek. done is high for the one cycle after Ek.
- Latency for en=0: done is high for the one cycle after E0.
- busy=1 from the cycle after E0 through the cycle in which the result is registered; busy=0 in the cycle where done=1.
- Result outputs change only on the edge that sets done, or on reset. At an accepting edge, the previous result is cleared.
- rst mid-run forces the reset values on the next edge. No done pulse is issued for the aborted comparison.

## Configuration
- SIGNED_CMP_EN:
  - Defined: the sgn port exists. With sgn=1, operands are two's complement and the MSB decision is inverted, because a set MSB marks the smaller value. Lower bits use the unsigned rule.
  - Undefined: the sgn port is absent, comparison is always unsigned, and no MSB inversion logic is built.

## Structure
- Shared package cmp_pkg:
  - state typedef {IDLE, RUN}.
  - Result-vector bit-position constants, matching the existing {S, I, E} order: 2=gt, 1=lt, 0=eq.
- Sub-module cmp_bit_cell: a 1-bit cell with inputs g, a and b and outputs gt, lt and eq, all gated by g. It holds the combinational per-bit decision; the FSM, index counter and result registers stay in seq_mag_cmp.

## Test plan
All cases use WIDTH=8.
- a=0xA5, b=0xA5, en=1, start=1 → done 8 cycles after the accepting edge; eq=1, gt=0, lt=0; busy high for 8 cycles.
- a=0x80, b=0x7F, en=1 → done 1 cycle after start with gt=1. With SIGNED_CMP_EN and sgn=1 → lt=1.
- a=0x12, b=0x13, en=1 → done 8 cycles after start with lt=1. Then a=0x40, b=0x10 → done 2 cycles after start with gt=1.
- en=0, a=0xFF, b=0x00 → done 1 cycle after start; gt=lt=eq=0; busy never rises.
- Start a=0x01, b=0x00; pulse start again with new operands during cycle 3 → ignored; result gt=1 at cycle 8. Then repeat with rst=1 in cycle 3 → busy=0, all outputs 0, no done pulse.
- Hold start high continuously with alternating operands → a new comparison is accepted on each done cycle, and results match a golden unsigned compare over 1000 random pairs.
